// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: writable instruction memory, PC and IDLE/RUN/HALT sequencer
// streaming words to decode. Define IF_FETCH_TRACE_EN to get a simulation trace of fetches.
module if_fetch_unit #(
  parameter int INST_CAP = 32,
  parameter int INST_LEN = 17,
  parameter int PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                wr_en,
  input  logic [PC_W-1:0]     wr_addr,
  input  logic [INST_LEN-1:0] wr_data,
  output logic [INST_LEN-1:0] inst,
  output logic [PC_W-1:0]     inst_pc,
  output logic                inst_valid,
  output logic                halted
);

  localparam int              ADDR_W = (INST_CAP > 1) ? $clog2(INST_CAP) : 1;
  localparam logic [PC_W-1:0] CAP_PC = PC_W'(INST_CAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halted_q, halted_d;
  logic [INST_LEN-1:0] mem_q [INST_CAP];
  logic [INST_LEN-1:0] mem_rdata_s;

  // Read is gated by the range check so an out-of-range PC never indexes the array.
  assign mem_rdata_s = (pc_q < CAP_PC) ? mem_q[pc_q[ADDR_W-1:0]] : '0;

  // Loader write port; no reset so contents survive rstn. Non-blocking gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < CAP_PC)) begin
      mem_q[wr_addr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Sequencer next-state and fetch datapath.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    case (state_q)
      ST_IDLE: begin
        inst_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
          if (redirect_pc >= CAP_PC) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
          end
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (pc_q < CAP_PC) begin
          inst_d       = mem_rdata_s;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + PC_W'(1'b1);
        end else begin
          // PC never wraps: running off the end of memory always halts.
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
          state_d      = ST_HALT;
        end
      end
      ST_HALT: begin
        inst_valid_d = 1'b0;
        halted_d     = 1'b1;
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
        end else begin
          state_d  = ST_HALT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

`ifdef IF_FETCH_TRACE_EN
  logic trace_fetch_s;
  logic trace_redirect_s;
  logic trace_halt_s;

  assign trace_fetch_s    = (state_q == ST_RUN) && !redirect && !stall && (pc_q < CAP_PC);
  assign trace_redirect_s = (state_q == ST_RUN) && redirect;
  assign trace_halt_s     = (state_q != ST_HALT) && (state_d == ST_HALT);

  // Trace printed at the edge that commits each event.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (trace_fetch_s) begin
        $display("%0t [IF] pc=%0d inst=%b", $time, pc_q, mem_rdata_s);
      end
      if (trace_redirect_s) begin
        $display("%0t [IF] redirect pc=%0d -> %0d", $time, pc_q, redirect_pc);
      end
      if (trace_halt_s) begin
        $display("%0t [IF] halt at pc=%0d", $time, pc_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a 16-word instance for most scenarios and a
// 4-word instance for the run-off-the-end sequence.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stall, redirect;
  logic [4:0]  redirect_pc;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [16:0] wr_data;
  logic [16:0] inst;
  logic [4:0]  inst_pc;
  logic        inst_valid, halted;

  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [16:0] s_wr_data;
  logic [2:0]  s_redirect_pc;
  logic [16:0] s_inst;
  logic [2:0]  s_inst_pc;
  logic        s_inst_valid, s_halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.INST_CAP(16), .INST_LEN(17)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .halted(halted)
  );

  if_fetch_unit #(.INST_CAP(4), .INST_LEN(17)) dut_small (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(s_redirect_pc), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .inst(s_inst), .inst_pc(s_inst_pc), .inst_valid(s_inst_valid), .halted(s_halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_big();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 17'h00100 + 17'(i);
      s_wr_en   = (i < 4);
      s_wr_addr = 3'(i);
      s_wr_data = 17'h00001 + 17'(i);
      step();
    end
    wr_en   = 1'b0;
    s_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({inst_valid, halted, inst_pc, inst} !== {1'b0, 1'b0, 5'd0, 17'h00000}) begin
      miscompares++;
      $display("FAIL reset_big: got %h exp %h", {inst_valid, halted, inst_pc, inst}, 24'h0);
    end
    vectors++;
    if ({s_inst_valid, s_halted, s_inst_pc, s_inst} !== {1'b0, 1'b0, 3'd0, 17'h00000}) begin
      miscompares++;
      $display("FAIL reset_small: got %h exp %h", {s_inst_valid, s_halted, s_inst_pc, s_inst}, 22'h0);
    end
    step();
    rstn = 1'b1;
    redirect = 1'b1; redirect_pc = 5'd20; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    vectors++;
    if ({inst_valid, halted} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_ignores_redirect: got %b exp %b", {inst_valid, halted}, 2'b00);
    end
  endtask

  task automatic test_sequence();
    start_big();
    vectors++;
    if (s_inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_first_cycle: valid got %b exp 0", s_inst_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({s_inst_valid, s_halted, s_inst_pc, s_inst} !== {1'b1, 1'b0, 3'(k), 17'h00001 + 17'(k)}) begin
        miscompares++;
        $display("FAIL seq_word%0d: got %h exp %h", k, {s_inst_valid, s_halted, s_inst_pc, s_inst},
                 {1'b1, 1'b0, 3'(k), 17'h00001 + 17'(k)});
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({s_inst_valid, s_halted} !== 2'b01) begin
        miscompares++;
        $display("FAIL seq_halt%0d: valid,halted got %b exp 01", k, {s_inst_valid, s_halted});
      end
    end
    for (int n = 0; n < 40 && !halted; n++) step();
    vectors++;
    if ({inst_valid, halted, inst_pc} !== {1'b0, 1'b1, 5'd15}) begin
      miscompares++;
      $display("FAIL big_runs_off_end: got %h exp %h", {inst_valid, halted, inst_pc}, {1'b0, 1'b1, 5'd15});
    end
  endtask

  task automatic test_stall();
    start_big();
    step();
    step();
    vectors++;
    if ({inst_valid, halted, inst_pc, inst} !== {1'b1, 1'b0, 5'd1, 17'h00101}) begin
      miscompares++;
      $display("FAIL restart_pc1: got %h exp %h", {inst_valid, halted, inst_pc, inst}, {1'b1, 1'b0, 5'd1, 17'h00101});
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd1, 17'h00101}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got %h exp %h", k, {inst_valid, inst_pc, inst}, {1'b1, 5'd1, 17'h00101});
      end
    end
    stall = 1'b0;
    for (int k = 2; k < 4; k++) begin
      step();
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 5'(k), 17'h00100 + 17'(k)}) begin
        miscompares++;
        $display("FAIL stall_resume%0d: got %h exp %h", k, {inst_valid, inst_pc, inst}, {1'b1, 5'(k), 17'h00100 + 17'(k)});
      end
    end
  endtask

  task automatic test_redirect();
    for (int pass = 0; pass < 2; pass++) begin
      redirect = 1'b1; redirect_pc = 5'd10; stall = (pass == 1);
      step();
      redirect = 1'b0; stall = 1'b0;
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_flush%0d: valid got %b exp 0", pass, inst_valid);
      end
      step();
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd10, 17'h0010a}) begin
        miscompares++;
        $display("FAIL redirect_target%0d: got %h exp %h", pass, {inst_valid, inst_pc, inst}, {1'b1, 5'd10, 17'h0010a});
      end
      if (pass == 0) step();
    end
  endtask

  task automatic test_write_collision();
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 17'h1FFFF;
    step();
    wr_en = 1'b0;
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd11, 17'h0010b}) begin
      miscompares++;
      $display("FAIL rbw_old_value: got %h exp %h", {inst_valid, inst_pc, inst}, {1'b1, 5'd11, 17'h0010b});
    end
    redirect = 1'b1; redirect_pc = 5'd11;
    step();
    redirect = 1'b0;
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd11, 17'h1FFFF}) begin
      miscompares++;
      $display("FAIL rbw_new_value: got %h exp %h", {inst_valid, inst_pc, inst}, {1'b1, 5'd11, 17'h1FFFF});
    end
    wr_en = 1'b1; wr_addr = 5'd16; wr_data = 17'h0AAAA;
    redirect = 1'b1; redirect_pc = 5'd0;
    step();
    wr_en = 1'b0; redirect = 1'b0;
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd0, 17'h00100}) begin
      miscompares++;
      $display("FAIL oob_write_discarded: got %h exp %h", {inst_valid, inst_pc, inst}, {1'b1, 5'd0, 17'h00100});
    end
  endtask

  task automatic test_redirect_halt();
    redirect = 1'b1; redirect_pc = 5'd17;
    step();
    redirect = 1'b0;
    vectors++;
    if ({inst_valid, halted} !== 2'b01) begin
      miscompares++;
      $display("FAIL oob_redirect_halt: got %b exp 01", {inst_valid, halted});
    end
    redirect = 1'b1; redirect_pc = 5'd2;
    step();
    redirect = 1'b0;
    step();
    vectors++;
    if ({inst_valid, halted} !== 2'b01) begin
      miscompares++;
      $display("FAIL halt_ignores_redirect: got %b exp 01", {inst_valid, halted});
    end
    start_big();
    vectors++;
    if ({inst_valid, halted} !== 2'b00) begin
      miscompares++;
      $display("FAIL restart_clears_halt: got %b exp 00", {inst_valid, halted});
    end
    step();
    vectors++;
    if ({inst_valid, halted, inst_pc, inst} !== {1'b1, 1'b0, 5'd0, 17'h00100}) begin
      miscompares++;
      $display("FAIL restart_first: got %h exp %h", {inst_valid, halted, inst_pc, inst}, {1'b1, 1'b0, 5'd0, 17'h00100});
    end
    step();
  endtask

  task automatic test_async_reset();
    #3;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({inst_valid, halted, inst_pc, inst} !== {1'b0, 1'b0, 5'd0, 17'h00000}) begin
      miscompares++;
      $display("FAIL async_reset_clear: got %h exp %h", {inst_valid, halted, inst_pc, inst}, 24'h0);
    end
    step();
    rstn = 1'b1;
    step();
    vectors++;
    if ({inst_valid, halted} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b exp 00", {inst_valid, halted});
    end
    start_big();
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd0, 17'h00100}) begin
      miscompares++;
      $display("FAIL post_reset_pc0: got %h exp %h", {inst_valid, inst_pc, inst}, {1'b1, 5'd0, 17'h00100});
    end
    redirect = 1'b1; redirect_pc = 5'd11;
    step();
    redirect = 1'b0;
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 5'd11, 17'h1FFFF}) begin
      miscompares++;
      $display("FAIL mem_preserved: got %h exp %h", {inst_valid, inst_pc, inst}, {1'b1, 5'd11, 17'h1FFFF});
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 5'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 17'h0;
    s_wr_en = 1'b0; s_wr_addr = 3'd0; s_wr_data = 17'h0; s_redirect_pc = 3'd0;
    test_reset();
    load_mem();
    test_sequence();
    test_stall();
    test_redirect();
    test_write_collision();
    test_redirect_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
